serdiv_req_ctrl: RTL and testbench

//  Issue-side initiator for the serial divider: accepts one div/rem request from the issue stage,

---
 rtl/serdiv_req_ctrl_if.sv | 54 +++++
 rtl/serdiv_req_ctrl.sv | 166 ++++++++++++++++
 tb/tb_serdiv_req_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdiv_req_ctrl_if.sv
// Handshake bundle between serdiv_req_ctrl and its surroundings.
//   Issue side : flush, req_valid/req_ready, req_id, req_op_a, req_op_b, req_opcode
//   Divider    : div_in_vld/div_in_rdy, div_id/div_op_a/div_op_b/div_opcode (issued operands),
//                div_flush, div_out_vld/div_out_rdy, div_rsp_id (returned id), div_res
//   Writeback  : wb_valid/wb_ready, wb_id, wb_result
//   Status     : busy, timeout (sticky), id_err (sticky)
// modport master is the controller's view; modport slave is the environment's view.
interface serdiv_req_ctrl_if #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic                     flush;
  logic                     req_valid;
  logic                     req_ready;
  logic [TRANS_ID_BITS-1:0] req_id;
  logic [WIDTH-1:0]         req_op_a;
  logic [WIDTH-1:0]         req_op_b;
  logic [1:0]               req_opcode;

  logic                     div_in_vld;
  logic                     div_in_rdy;
  logic [TRANS_ID_BITS-1:0] div_id;
  logic [WIDTH-1:0]         div_op_a;
  logic [WIDTH-1:0]         div_op_b;
  logic [1:0]               div_opcode;
  logic                     div_flush;
  logic                     div_out_vld;
  logic                     div_out_rdy;
  logic [TRANS_ID_BITS-1:0] div_rsp_id;
  logic [WIDTH-1:0]         div_res;

  logic                     wb_valid;
  logic                     wb_ready;
  logic [TRANS_ID_BITS-1:0] wb_id;
  logic [WIDTH-1:0]         wb_result;

  logic                     busy;
  logic                     timeout;
  logic                     id_err;

  modport master (
    input  flush, req_valid, req_id, req_op_a, req_op_b, req_opcode,
    input  div_in_rdy, div_out_vld, div_rsp_id, div_res, wb_ready,
    output req_ready, div_in_vld, div_id, div_op_a, div_op_b, div_opcode,
    output div_flush, div_out_rdy, wb_valid, wb_id, wb_result, busy, timeout, id_err
  );

  modport slave (
    output flush, req_valid, req_id, req_op_a, req_op_b, req_opcode,
    output div_in_rdy, div_out_vld, div_rsp_id, div_res, wb_ready,
    input  req_ready, div_in_vld, div_id, div_op_a, div_op_b, div_opcode,
    input  div_flush, div_out_rdy, wb_valid, wb_id, wb_result, busy, timeout, id_err
  );
endinterface

// File: rtl/serdiv_req_ctrl.sv
// Issue-side initiator for the serial divider. Accepts one div/rem request, presents it to the
// divider one cycle after the divider's registered in_rdy, waits for the result under a
// watchdog, and holds the result for the writeback arbiter. Only one request is in flight.
// Ports:
//   clk_i  clock
//   rst_i  synchronous, active-high reset
//   bus    serdiv_req_ctrl_if.master (issue, divider, writeback and status signals)
// Parameters:
//   WIDTH          operand/result width
//   TIMEOUT        max cycles spent waiting for a result before aborting (>= WIDTH+4)
//   TRANS_ID_BITS  transaction id width (ariane_pkg default)
module serdiv_req_ctrl #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TIMEOUT       = 127,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input logic               clk_i,
  input logic               rst_i,
  serdiv_req_ctrl_if.master bus
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWb
  } state_e;

  state_e                   state_q, state_d;
  logic                     rdy_q;
  logic [WdogW-1:0]         wdog_q, wdog_d;
  logic [TRANS_ID_BITS-1:0] id_q, id_d;
  logic [WIDTH-1:0]         op_a_q, op_a_d;
  logic [WIDTH-1:0]         op_b_q, op_b_d;
  logic [1:0]               opcode_q, opcode_d;
  logic [TRANS_ID_BITS-1:0] wb_id_q, wb_id_d;
  logic [WIDTH-1:0]         wb_res_q, wb_res_d;
  logic                     timeout_q, timeout_d;
  logic                     id_err_q, id_err_d;
  logic [WdogW-1:0]         wdog_inc;

  // Saturating increment; the timeout branch normally leaves WAIT before saturation matters.
  assign wdog_inc = (wdog_q == WdogMax) ? wdog_q : wdog_q + WdogW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rdy_q     <= 1'b0;
      wdog_q    <= '0;
      id_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      opcode_q  <= '0;
      wb_id_q   <= '0;
      wb_res_q  <= '0;
      timeout_q <= 1'b0;
      id_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Mirrors the divider's one-cycle in_rdy -> in_vld handshake delay.
      rdy_q     <= bus.div_in_rdy;
      wdog_q    <= wdog_d;
      id_q      <= id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opcode_q  <= opcode_d;
      wb_id_q   <= wb_id_d;
      wb_res_q  <= wb_res_d;
      timeout_q <= timeout_d;
      id_err_q  <= id_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wdog_d          = wdog_q;
    id_d            = id_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    opcode_d        = opcode_q;
    wb_id_d         = wb_id_q;
    wb_res_d        = wb_res_q;
    timeout_d       = timeout_q;
    id_err_d        = id_err_q;
    bus.req_ready   = 1'b0;
    bus.div_in_vld  = 1'b0;
    bus.div_out_rdy = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.div_flush   = 1'b0;

    if (bus.flush) begin
      // Kill everything: no handshake of any kind is offered in a flush cycle.
      bus.div_flush = 1'b1;
      state_d       = StIdle;
      wdog_d        = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            id_d     = bus.req_id;
            op_a_d   = bus.req_op_a;
            op_b_d   = bus.req_op_b;
            opcode_d = bus.req_opcode;
            state_d  = StIssue;
          end
        end
        StIssue: begin
          if (rdy_q) begin
            bus.div_in_vld = 1'b1;
            wdog_d         = '0;
            state_d        = StWait;
          end
        end
        StWait: begin
          bus.div_out_rdy = 1'b1;
          // A result arriving in the watchdog's final cycle still wins.
          if (bus.div_out_vld) begin
            wb_id_d  = bus.div_rsp_id;
            wb_res_d = bus.div_res;
            if (bus.div_rsp_id != id_q) begin
              id_err_d = 1'b1;
            end
            state_d = StWb;
          end else if (wdog_q == WdogMax) begin
            timeout_d     = 1'b1;
            bus.div_flush = 1'b1;
            state_d       = StIdle;
          end else begin
            wdog_d = wdog_inc;
          end
        end
        StWb: begin
          bus.wb_valid = 1'b1;
          if (bus.wb_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Reset dominates flush and all handshakes.
    if (rst_i) begin
      bus.req_ready   = 1'b0;
      bus.div_in_vld  = 1'b0;
      bus.div_out_rdy = 1'b0;
      bus.wb_valid    = 1'b0;
      bus.div_flush   = 1'b0;
    end
  end

  assign bus.div_id     = id_q;
  assign bus.div_op_a   = op_a_q;
  assign bus.div_op_b   = op_b_q;
  assign bus.div_opcode = opcode_q;
  assign bus.wb_id      = wb_id_q;
  assign bus.wb_result  = wb_res_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.timeout    = timeout_q;
  assign bus.id_err     = id_err_q;

endmodule

// File: tb/tb_serdiv_req_ctrl.sv
// Self-checking bench for serdiv_req_ctrl: the bench plays issue stage, divider and writeback
// arbiter, and checks each transaction against a transaction-level model of expected timing,
// operands, results and sticky flags.
module tb_serdiv_req_ctrl;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned TIMEOUT = 127;
  localparam int unsigned TIB     = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic exp_timeout;
  logic exp_id_err;

  serdiv_req_ctrl_if #(.WIDTH(WIDTH), .TRANS_ID_BITS(TIB)) bus ();

  serdiv_req_ctrl #(
    .WIDTH        (WIDTH),
    .TIMEOUT      (TIMEOUT),
    .TRANS_ID_BITS(TIB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // RISC-V M-extension divide/remainder semantics.
  function automatic logic [63:0] ref_divrem(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] op);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hffff_ffff_ffff_ffff);
    case (op)
      2'd0:    return (b == 0) ? 64'hffff_ffff_ffff_ffff : a / b;
      2'd1:    return (b == 0) ? 64'hffff_ffff_ffff_ffff : (ovf ? a : 64'(sa / sb));
      2'd2:    return (b == 0) ? a : a % b;
      default: return (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_timeout = 1'b0;
    exp_id_err  = 1'b0;
    tick();
  endtask

  // mode: 0 normal, 1 flush in ISSUE (k forced 0), 2 flush in WAIT at cycle L, 3 silent divider
  task automatic txn(input logic [2:0] id, input logic [63:0] a, input logic [63:0] b,
                     input logic [1:0] opc, input int k_in, input int lat, input int stall,
                     input logic [2:0] rid, input int mode);
    logic [63:0] res;
    int          k;
    k   = (mode == 1) ? 0 : k_in;
    res = ref_divrem(a, b, opc);

    check("idle_req_ready", 64'(bus.req_ready), 64'd1);
    check("idle_busy", 64'(bus.busy), 64'd0);
    bus.req_valid  = 1'b1;
    bus.req_id     = id;
    bus.req_op_a   = a;
    bus.req_op_b   = b;
    bus.req_opcode = opc;
    if (k > 0) bus.div_in_rdy = 1'b0;
    tick();
    // Scramble the request bus so any reload after accept would show up.
    bus.req_valid  = 1'b0;
    bus.req_id     = ~id;
    bus.req_op_a   = ~a;
    bus.req_op_b   = ~b;
    bus.req_opcode = ~opc;
    check("issue_busy", 64'(bus.busy), 64'd1);
    check("issue_req_ready", 64'(bus.req_ready), 64'd0);

    if (mode == 1) begin
      bus.flush = 1'b1;
      #1;
      check("flush_issue_in_vld", 64'(bus.div_in_vld), 64'd0);
      check("flush_issue_div_flush", 64'(bus.div_flush), 64'd1);
      tick();
      bus.flush = 1'b0;
      #1;
      check("flush_issue_idle", 64'(bus.busy), 64'd0);
      return;
    end

    for (int j = 1; j <= k; j++) begin
      check("issue_hold_in_vld", 64'(bus.div_in_vld), 64'd0);
      check("issue_hold_op_a", bus.div_op_a, a);
      if (j == k) bus.div_in_rdy = 1'b1;
      tick();
    end
    check("in_vld", 64'(bus.div_in_vld), 64'd1);
    check("div_id", 64'(bus.div_id), 64'(id));
    check("div_op_a", bus.div_op_a, a);
    check("div_op_b", bus.div_op_b, b);
    check("div_opcode", 64'(bus.div_opcode), 64'(opc));
    tick();
    check("wait_in_vld_single", 64'(bus.div_in_vld), 64'd0);

    if (mode == 3) begin
      for (int w = 0; w <= int'(TIMEOUT); w++) begin
        check("silent_out_rdy", 64'(bus.div_out_rdy), 64'd1);
        check("silent_div_flush", 64'(bus.div_flush), (w == int'(TIMEOUT)) ? 64'd1 : 64'd0);
        check("silent_timeout_flag", 64'(bus.timeout), 64'(exp_timeout));
        tick();
      end
      exp_timeout = 1'b1;
      check("timeout_set", 64'(bus.timeout), 64'd1);
      check("timeout_idle", 64'(bus.busy), 64'd0);
      check("timeout_req_ready", 64'(bus.req_ready), 64'd1);
      bus.div_out_vld = 1'b1;
      bus.div_res     = res;
      bus.div_rsp_id  = id;
      tick();
      bus.div_out_vld = 1'b0;
      check("timeout_stale_wb", 64'(bus.wb_valid), 64'd0);
      check("timeout_stale_busy", 64'(bus.busy), 64'd0);
      return;
    end

    for (int w = 0; w < lat; w++) begin
      check("wait_out_rdy", 64'(bus.div_out_rdy), 64'd1);
      check("wait_wb_valid", 64'(bus.wb_valid), 64'd0);
      tick();
    end

    if (mode == 2) begin
      bus.flush = 1'b1;
      #1;
      check("flush_wait_div_flush", 64'(bus.div_flush), 64'd1);
      check("flush_wait_out_rdy", 64'(bus.div_out_rdy), 64'd0);
      tick();
      bus.flush = 1'b0;
      #1;
      check("flush_wait_idle", 64'(bus.busy), 64'd0);
      check("flush_wait_req_ready", 64'(bus.req_ready), 64'd1);
      bus.div_out_vld = 1'b1;
      bus.div_res     = res;
      bus.div_rsp_id  = id;
      tick();
      bus.div_out_vld = 1'b0;
      check("flush_stale_wb", 64'(bus.wb_valid), 64'd0);
      check("flush_stale_busy", 64'(bus.busy), 64'd0);
      return;
    end

    check("reply_out_rdy", 64'(bus.div_out_rdy), 64'd1);
    bus.div_out_vld = 1'b1;
    bus.div_res     = res;
    bus.div_rsp_id  = rid;
    if (rid != id) exp_id_err = 1'b1;
    tick();
    bus.div_out_vld = 1'b0;
    bus.div_res     = rand64();
    bus.div_rsp_id  = ~rid;

    for (int s = 0; s < stall; s++) begin
      check("stall_wb_valid", 64'(bus.wb_valid), 64'd1);
      check("stall_wb_result", bus.wb_result, res);
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    check("wb_valid", 64'(bus.wb_valid), 64'd1);
    check("wb_result", bus.wb_result, res);
    check("wb_id", 64'(bus.wb_id), 64'(rid));
    check("id_err", 64'(bus.id_err), 64'(exp_id_err));
    check("timeout_sticky", 64'(bus.timeout), 64'(exp_timeout));
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    check("post_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("post_wb_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    exp_timeout    = 1'b0;
    exp_id_err     = 1'b0;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_id     = '0;
    bus.req_op_a   = '0;
    bus.req_op_b   = '0;
    bus.req_opcode = '0;
    bus.div_in_rdy = 1'b1;
    bus.div_out_vld = 1'b1;
    bus.div_rsp_id = '0;
    bus.div_res    = '0;
    bus.wb_ready   = 1'b1;
    rst            = 1'b1;

    // Reset with every request-like input asserted.
    tick();
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_in_vld", 64'(bus.div_in_vld), 64'd0);
    check("rst_out_rdy", 64'(bus.div_out_rdy), 64'd0);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    bus.flush = 1'b1;
    tick();
    check("rst_flush_busy", 64'(bus.busy), 64'd0);
    rst             = 1'b0;
    bus.flush       = 1'b0;
    bus.req_valid   = 1'b0;
    bus.div_out_vld = 1'b0;
    bus.wb_ready    = 1'b0;
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_timeout", 64'(bus.timeout), 64'd0);
    check("reset_id_err", 64'(bus.id_err), 64'd0);
    check("reset_wb_result", bus.wb_result, 64'd0);

    // Directed cases.
    txn(3'd3, 64'd100, 64'd7, 2'd0, 0, 2, 0, 3'd3, 0);
    txn(3'd1, 64'd1000, 64'd9, 2'd2, 3, 1, 0, 3'd1, 0);
    txn(3'd2, 64'hffff_ffff_ffff_fff0, 64'd5, 2'd1, 0, 0, 5, 3'd2, 0);
    txn(3'd4, 64'd55, 64'd0, 2'd3, 1, TIMEOUT, 1, 3'd4, 0);
    txn(3'd5, 64'd8, 64'd2, 2'd0, 0, 3, 0, 3'd5, 2);
    txn(3'd6, 64'd8, 64'd2, 2'd0, 0, 0, 0, 3'd6, 1);

    // Flush in IDLE drops a simultaneous request.
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    #1;
    check("flush_idle_req_ready", 64'(bus.req_ready), 64'd0);
    check("flush_idle_div_flush", 64'(bus.div_flush), 64'd1);
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("flush_idle_dropped", 64'(bus.busy), 64'd0);

    txn(3'd7, 64'd12345, 64'd11, 2'd0, 0, 0, 0, 3'd7, 3);
    txn(3'd3, 64'd100, 64'd7, 2'd0, 0, 1, 0, 3'd5, 0);
    txn(3'd0, 64'd9, 64'd3, 2'd2, 0, 0, 0, 3'd0, 0);
    do_reset();
    check("reset_clears_id_err", 64'(bus.id_err), 64'd0);
    check("reset_clears_timeout", 64'(bus.timeout), 64'd0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  id;
      logic [2:0]  rid;
      logic [63:0] a;
      logic [63:0] b;
      int          mode;
      int          sel;
      id  = 3'($urandom_range(0, 7));
      rid = ($urandom_range(0, 7) == 0) ? id + 3'd1 : id;
      a   = rand64();
      sel = int'($urandom_range(0, 3));
      b   = (sel == 0) ? 64'd0 : (sel == 1) ? 64'($urandom_range(1, 100)) : rand64();
      sel = int'($urandom_range(0, 7));
      mode = (sel == 6) ? 1 : (sel == 7) ? 2 : 0;
      txn(id, a, b, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), rid, mode);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
